// File: rtl/branch_predict_unit_pkg.sv
// Shared widths, BHT counter encodings and helpers for the branch predictor.
package bp_pkg;

  localparam int BTB_IDX_W = 6;
  localparam int BHT_IDX_W = 12;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RST = WNT;

  // Word-aligned PCs: two low bits and the index bits are not part of the tag.
  function automatic int tag_w(input int idx_w);
    return 32 - idx_w - 2;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side signals of the branch predictor: IF lookup, EX training, stats.
interface branch_predict_unit_if #(parameter int CNT_W = bp_pkg::CNT_W);

  logic [31:0]      PCF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic [31:0]      PCE;
  logic             BrInstE;
  logic             BranchE;
  logic [31:0]      BranchTarget;
  logic [31:0]      PredictPC;
  logic             BTB_HitF;
  logic             BHT_HitF;
  logic             BTB_HitE;
  logic             BHT_HitE;
  logic             MispredictE;
  logic [CNT_W-1:0] BrCount;
  logic [CNT_W-1:0] MissCount;

  modport master (
    output PCF, StallD, FlushD, StallE, FlushE, PCE, BrInstE, BranchE, BranchTarget,
    input  PredictPC, BTB_HitF, BHT_HitF, BTB_HitE, BHT_HitE, MispredictE, BrCount, MissCount
  );

  modport slave (
    input  PCF, StallD, FlushD, StallE, FlushE, PCE, BrInstE, BranchE, BranchTarget,
    output PredictPC, BTB_HitF, BHT_HitF, BTB_HitE, BHT_HitE, MispredictE, BrCount, MissCount
  );

endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating branch-history counter.
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic     taken,
  input  bht_cnt_e cur,
  output bht_cnt_e nxt
);

  always_comb begin
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB + BHT predictor: IF-stage lookup, hit bits carried to EX, EX-stage training
// and mispredict/statistics reporting.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int BTB_IDX_W = bp_pkg::BTB_IDX_W,
  parameter int BHT_IDX_W = bp_pkg::BHT_IDX_W,
  parameter int CNT_W     = bp_pkg::CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_unit_if.slave bp
);

  localparam int BTB_ENT = 1 << BTB_IDX_W;
  localparam int BHT_ENT = 1 << BHT_IDX_W;
  localparam int TAG_W   = tag_w(BTB_IDX_W);

  logic             btb_valid  [BTB_ENT];
  logic [TAG_W-1:0] btb_tag    [BTB_ENT];
  logic [31:0]      btb_target [BTB_ENT];
  bht_cnt_e         bht        [BHT_ENT];

  logic [BTB_IDX_W-1:0] f_btb_idx, e_btb_idx;
  logic [BHT_IDX_W-1:0] f_bht_idx, e_bht_idx;
  logic [TAG_W-1:0]     f_tag, e_tag;
  logic [1:0]           hit_d, hit_e;
  logic                 btb_hit_f, bht_hit_f, pred_taken, mispredict, train;
  bht_cnt_e             bht_nxt;
  logic [CNT_W-1:0]     br_cnt, miss_cnt;
  logic                 unused_pc_lsbs;

  assign f_btb_idx = bp.PCF[BTB_IDX_W+1:2];
  assign f_tag     = bp.PCF[31:BTB_IDX_W+2];
  assign f_bht_idx = bp.PCF[BHT_IDX_W+1:2];
  assign e_btb_idx = bp.PCE[BTB_IDX_W+1:2];
  assign e_tag     = bp.PCE[31:BTB_IDX_W+2];
  assign e_bht_idx = bp.PCE[BHT_IDX_W+1:2];
  assign unused_pc_lsbs = ^{bp.PCF[1:0], bp.PCE[1:0]};

  // Reads see pre-write contents; training lands at the edge.
  assign btb_hit_f    = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign bht_hit_f    = bht[f_bht_idx][1];
  assign bp.BTB_HitF  = btb_hit_f;
  assign bp.BHT_HitF  = bht_hit_f;
  assign bp.PredictPC = btb_target[f_btb_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d <= 2'b00;
      hit_e <= 2'b00;
    end else begin
      if (bp.FlushD)      hit_d <= 2'b00;
      else if (!bp.StallD) hit_d <= {btb_hit_f, bht_hit_f};
      if (bp.FlushE)      hit_e <= 2'b00;
      else if (!bp.StallE) hit_e <= hit_d;
    end
  end

  assign bp.BTB_HitE    = hit_e[1];
  assign bp.BHT_HitE    = hit_e[0];
  assign pred_taken     = hit_e[1] & hit_e[0];
  assign mispredict     = bp.BrInstE & (bp.BranchE ^ pred_taken);
  assign bp.MispredictE = mispredict;
  assign train          = bp.BrInstE & ~bp.StallE & ~bp.FlushE;

  bp_sat_counter2 u_bht_upd (
    .taken (bp.BranchE),
    .cur   (bht[e_bht_idx]),
    .nxt   (bht_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENT; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      for (int i = 0; i < BHT_ENT; i++) bht[i] <= BHT_RST;
    end else if (train) begin
      bht[e_bht_idx] <= bht_nxt;
      if (bp.BranchE) begin
        btb_valid[e_btb_idx]  <= 1'b1;
        btb_tag[e_btb_idx]    <= e_tag;
        btb_target[e_btb_idx] <= bp.BranchTarget;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (train) begin
      br_cnt   <= br_cnt + 1'b1;
      miss_cnt <= miss_cnt + CNT_W'(mispredict);
    end
  end

  assign bp.BrCount   = br_cnt;
  assign bp.MissCount = miss_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  branch_predict_unit_if bpif ();

  branch_predict_unit dut (
    .clk (clk),
    .rst (rst),
    .bp  (bpif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Park PCF for two cycles with no branch in EX so the hit pipeline holds its lookup.
  task automatic fill(input logic [31:0] pc);
    bpif.PCF     = pc;
    bpif.BrInstE = 1'b0;
    step();
    step();
  endtask

  task automatic ex_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bpif.PCE          = pc;
    bpif.BrInstE      = 1'b1;
    bpif.BranchE      = taken;
    bpif.BranchTarget = tgt;
  endtask

  initial begin
    rst               = 1'b1;
    bpif.PCF          = '0;
    bpif.StallD       = 1'b0;
    bpif.FlushD       = 1'b0;
    bpif.StallE       = 1'b0;
    bpif.FlushE       = 1'b0;
    bpif.PCE          = '0;
    bpif.BrInstE      = 1'b0;
    bpif.BranchE      = 1'b0;
    bpif.BranchTarget = '0;
    step();
    step();
    rst = 1'b0;

    // post-reset lookup
    bpif.PCF = 32'h40;
    #1;
    chk("rst_btb_hitf", 32'(bpif.BTB_HitF), 0);
    chk("rst_bht_hitf", 32'(bpif.BHT_HitF), 0);
    chk("rst_btb_hite", 32'(bpif.BTB_HitE), 0);
    chk("rst_brcount",  bpif.BrCount, 0);
    chk("rst_misscount", bpif.MissCount, 0);

    // two taken resolutions of 0x40 -> 0x80
    bpif.PCF = 32'h100;
    ex_branch(32'h40, 1'b1, 32'h80);
    #1;
    chk("t1_mispred", 32'(bpif.MispredictE), 1);
    step();
    chk("t2_mispred", 32'(bpif.MispredictE), 1);
    step();
    bpif.BrInstE = 1'b0;
    bpif.PCF     = 32'h40;
    #1;
    chk("trained_btb_hitf", 32'(bpif.BTB_HitF), 1);
    chk("trained_predpc",   bpif.PredictPC, 32'h80);
    chk("trained_bht_hitf", 32'(bpif.BHT_HitF), 1);
    chk("trained_brcount",  bpif.BrCount, 2);
    chk("trained_miss",     bpif.MissCount, 2);

    // strongly taken, resolves not-taken twice
    fill(32'h40);
    chk("st_btb_hite", 32'(bpif.BTB_HitE), 1);
    chk("st_bht_hite", 32'(bpif.BHT_HitE), 1);
    ex_branch(32'h40, 1'b0, 32'h0);
    #1;
    chk("nt1_mispred", 32'(bpif.MispredictE), 1);
    step();
    bpif.BrInstE = 1'b0;
    #1;
    chk("nt1_bht_hitf", 32'(bpif.BHT_HitF), 1);
    chk("nt1_no_br_mispred", 32'(bpif.MispredictE), 0);
    fill(32'h40);
    ex_branch(32'h40, 1'b0, 32'h0);
    #1;
    chk("nt2_mispred", 32'(bpif.MispredictE), 1);
    step();
    bpif.BrInstE = 1'b0;
    #1;
    chk("nt2_bht_hitf", 32'(bpif.BHT_HitF), 0);
    chk("nt2_btb_hitf", 32'(bpif.BTB_HitF), 1);
    chk("nt2_brcount",  bpif.BrCount, 4);
    chk("nt2_miss",     bpif.MissCount, 4);

    // correctly predicted not-taken: BTB hit but BHT says not taken
    fill(32'h40);
    chk("cp_bht_hite", 32'(bpif.BHT_HitE), 0);
    ex_branch(32'h40, 1'b0, 32'h0);
    #1;
    chk("cp_mispred", 32'(bpif.MispredictE), 0);
    step();
    chk("cp_brcount", bpif.BrCount, 5);
    chk("cp_miss",    bpif.MissCount, 4);

    // aliasing: 0x1040 shares the BTB slot of 0x40
    ex_branch(32'h1040, 1'b1, 32'h300);
    step();
    bpif.BrInstE = 1'b0;
    bpif.PCF     = 32'h40;
    #1;
    chk("alias_old_hitf", 32'(bpif.BTB_HitF), 0);
    chk("alias_old_bht",  32'(bpif.BHT_HitF), 0);
    bpif.PCF = 32'h1040;
    #1;
    chk("alias_new_hitf", 32'(bpif.BTB_HitF), 1);
    chk("alias_new_pc",   bpif.PredictPC, 32'h300);
    chk("alias_new_bht",  32'(bpif.BHT_HitF), 1);
    chk("alias_brcount",  bpif.BrCount, 6);
    chk("alias_miss",     bpif.MissCount, 5);

    // EX stall holds training off for three cycles
    fill(32'h200);
    ex_branch(32'h80, 1'b1, 32'h400);
    bpif.StallE = 1'b1;
    step();
    step();
    step();
    bpif.PCF = 32'h80;
    #1;
    chk("stall_brcount", bpif.BrCount, 6);
    chk("stall_btb_hitf", 32'(bpif.BTB_HitF), 0);
    bpif.StallE = 1'b0;
    bpif.PCF    = 32'h200;
    step();
    bpif.BrInstE = 1'b0;
    bpif.PCF     = 32'h80;
    #1;
    chk("unstall_brcount", bpif.BrCount, 7);
    chk("unstall_miss",    bpif.MissCount, 6);
    chk("unstall_hitf",    32'(bpif.BTB_HitF), 1);
    chk("unstall_predpc",  bpif.PredictPC, 32'h400);
    chk("unstall_bht",     32'(bpif.BHT_HitF), 1);

    // FlushD kills the hit travelling from IF
    bpif.FlushD = 1'b1;
    step();
    bpif.FlushD = 1'b0;
    bpif.PCF    = 32'h200;
    step();
    chk("flushd_btb_hite", 32'(bpif.BTB_HitE), 0);
    bpif.PCF = 32'h80;
    step();
    bpif.PCF = 32'h200;
    step();
    chk("noflush_btb_hite", 32'(bpif.BTB_HitE), 1);
    chk("noflush_bht_hite", 32'(bpif.BHT_HitE), 1);

    // reset mid-stream with a branch waiting to train
    ex_branch(32'h80, 1'b1, 32'h500);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    bpif.PCF = 32'h80;
    #1;
    chk("mrst_btb_hitf", 32'(bpif.BTB_HitF), 0);
    chk("mrst_bht_hitf", 32'(bpif.BHT_HitF), 0);
    chk("mrst_btb_hite", 32'(bpif.BTB_HitE), 0);
    chk("mrst_bht_hite", 32'(bpif.BHT_HitE), 0);
    chk("mrst_mispred",  32'(bpif.MispredictE), 1);
    chk("mrst_predpc",   bpif.PredictPC, 0);
    chk("mrst_brcount",  bpif.BrCount, 0);
    chk("mrst_miss",     bpif.MissCount, 0);
    bpif.BrInstE = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
